// File: rtl/mon_tp_pkg.sv
// Shared types and constants for the monitor-side time-pulse checker.
package mon_tp_pkg;

   typedef enum logic [2:0] {
      ST_RUN,
      ST_STOP_PEND,
      ST_STOPPED,
      ST_STEP_PULSE,
      ST_STEP_RUN
   } tp_state_t;

   localparam logic [3:0] TP_ANY  = 4'd0;
   localparam logic [3:0] TP_LAST = 4'd12;

   // Successor pulse number; T12 is followed by T01.
   function automatic logic [3:0] tp_next(input logic [3:0] k);
      return (k == TP_LAST) ? 4'd1 : k + 4'd1;
   endfunction

endpackage

// File: rtl/mon_tp_edge.sv
// Registers the MT time-pulse bus once and derives per-pulse rise/fall strobes
// plus a flag for more than one pulse high in the same cycle.
module mon_tp_edge (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [11:0] i_mt,
   output logic [11:0] o_rise,
   output logic [11:0] o_fall,
   output logic        o_multi
);

   logic [11:0] r_mt_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_mt_q <= '0;
      else       r_mt_q <= i_mt;
   end

   assign o_rise  = i_mt & ~r_mt_q;
   assign o_fall  = ~i_mt & r_mt_q;
   // Clearing the lowest set bit leaves something only if two or more were set.
   assign o_multi = |(i_mt & (i_mt - 12'd1));

endmodule

// File: rtl/mon_tp_monitor.sv
// Monitor partner of the A2 timer: stop/step/run handshake, pulse sequence check,
// MCT counter. Optional stall watchdog built when MON_TP_WDOG_EN is defined.
module mon_tp_monitor
   import mon_tp_pkg::*;
#(
   parameter int STRT_W   = 2,
   parameter int CNT_W    = 16,
   parameter int WDOG_CYC = 256
) (
   input  logic             i_clock,
   input  logic             i_rst,
   input  logic [11:0]      i_mt,
   input  logic             i_monwt,
   input  logic             i_mgojam,
   input  logic             i_stop_req,
   input  logic             i_step_req,
   input  logic             i_run_req,
   output logic             o_mstp,
   output logic             o_mstrtp,
   output logic             o_stopped,
   output logic [3:0]       o_tpnum,
   output logic [CNT_W-1:0] o_mct_cnt,
   output logic             o_seqerr,
   output logic             o_stall
);

   localparam int SC_W = $clog2(STRT_W + 1);

   logic [11:0]      w_rise;
   logic [11:0]      w_fall;
   logic             w_multi;
   logic             w_fall12;
   logic             w_unused;
   logic [3:0]       w_rise_tp;

   tp_state_t        r_state;
   tp_state_t        w_nxt_state;
   logic             r_step;
   logic             w_nxt_step;
   logic [SC_W-1:0]  r_strt_cnt;

   logic [3:0]       r_exp;
   logic [3:0]       r_tpnum;
   logic [CNT_W-1:0] r_mct;
   logic             r_monwt_seen;
   logic             r_seqerr;

   mon_tp_edge u_edge (
      .i_clk   (i_clock),
      .i_rst   (i_rst),
      .i_mt    (i_mt),
      .o_rise  (w_rise),
      .o_fall  (w_fall),
      .o_multi (w_multi)
   );

   assign w_fall12 = w_fall[11];
   assign w_unused = ^w_fall[10:0];

   // Lowest rising pulse wins; simultaneous rises are already a one-hot error.
   always_comb begin
      w_rise_tp = TP_ANY;
      for (int i = 11; i >= 0; i--) begin
         if (w_rise[i]) w_rise_tp = 4'(i + 1);
      end
   end

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_step  = r_step;
      case (r_state)
         ST_RUN: begin
            if (i_stop_req) w_nxt_state = ST_STOP_PEND;
         end
         ST_STOP_PEND, ST_STEP_RUN: begin
            // GOJAM restarts the MCT, so it counts as the boundary.
            if (i_mgojam || w_fall12) w_nxt_state = ST_STOPPED;
         end
         ST_STOPPED: begin
            if (i_step_req) begin
               w_nxt_state = ST_STEP_PULSE;
               w_nxt_step  = 1'b1;
            end else if (i_run_req) begin
               w_nxt_state = ST_STEP_PULSE;
               w_nxt_step  = 1'b0;
            end
         end
         ST_STEP_PULSE: begin
            if (r_strt_cnt == SC_W'(STRT_W - 1))
               w_nxt_state = r_step ? ST_STEP_RUN : ST_RUN;
         end
         default: w_nxt_state = ST_RUN;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_rst) begin
         r_state    <= ST_RUN;
         r_step     <= 1'b0;
         r_strt_cnt <= '0;
      end else begin
         r_state    <= w_nxt_state;
         r_step     <= w_nxt_step;
         r_strt_cnt <= (r_state == ST_STEP_PULSE) ? r_strt_cnt + SC_W'(1) : '0;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_rst) begin
         r_exp        <= TP_ANY;
         r_tpnum      <= TP_ANY;
         r_mct        <= '0;
         r_monwt_seen <= 1'b0;
         r_seqerr     <= 1'b0;
      end else begin
         if (w_multi ||
             (!i_mgojam && w_rise_tp != TP_ANY && r_exp != TP_ANY && w_rise_tp != r_exp))
            r_seqerr <= 1'b1;

         if (w_rise[0])    r_monwt_seen <= i_monwt;
         else if (i_monwt) r_monwt_seen <= 1'b1;

         if (i_mgojam) begin
            r_exp   <= TP_ANY;
            r_tpnum <= TP_ANY;
         end else begin
            if (w_rise_tp != TP_ANY) begin
               r_exp   <= tp_next(w_rise_tp);
               r_tpnum <= w_rise_tp;
            end
            if (w_fall12 && r_monwt_seen) r_mct <= r_mct + CNT_W'(1);
         end
      end
   end

`ifdef MON_TP_WDOG_EN
   localparam int WD_W = $clog2(WDOG_CYC + 1);

   logic [WD_W-1:0] r_wdog;
   logic            r_stall;

   always_ff @(posedge i_clock) begin
      if (i_rst) begin
         r_wdog  <= '0;
         r_stall <= 1'b0;
      end else begin
         if (|w_rise || r_state == ST_STOPPED || r_state == ST_STOP_PEND)
            r_wdog <= '0;
         else if (r_wdog != WD_W'(WDOG_CYC))
            r_wdog <= r_wdog + WD_W'(1);
         if (r_wdog == WD_W'(WDOG_CYC)) r_stall <= 1'b1;
      end
   end

   assign o_stall = r_stall;
`else
   // No watchdog in this build; the expression is constant false.
   assign o_stall = (WDOG_CYC < 0);
`endif

   assign o_mstp    = (r_state == ST_STOP_PEND) || (r_state == ST_STOPPED) ||
                      (r_state == ST_STEP_RUN);
   assign o_mstrtp  = (r_state == ST_STEP_PULSE);
   assign o_stopped = (r_state == ST_STOPPED);
   assign o_tpnum   = r_tpnum;
   assign o_mct_cnt = r_mct;
   assign o_seqerr  = r_seqerr;

endmodule
